// File: rtl/flash_prog_if.sv
// SPI byte-master and SRAM read port bundle for the flash programmer.
// master = programmer side, slave = SPI master / SRAM side.
interface flash_prog_if;
  logic        spi_start_o;
  logic [7:0]  spi_out_o;
  logic [7:0]  spi_in_i;
  logic        spi_done_i;
  logic        spi_busy_i;
  logic        flash_csb_o;
  logic        sram_rd_en_o;
  logic [31:0] sram_addr_o;
  logic [31:0] sram_data_i;

  modport master (
    output spi_start_o, spi_out_o, flash_csb_o,
    output sram_rd_en_o, sram_addr_o,
    input  spi_in_i, spi_done_i, spi_busy_i,
    input  sram_data_i
  );

  modport slave (
    input  spi_start_o, spi_out_o, flash_csb_o,
    input  sram_rd_en_o, sram_addr_o,
    output spi_in_i, spi_done_i, spi_busy_i,
    output sram_data_i
  );
endinterface

// File: rtl/flash_prog_fsm.sv
// Copies PROG_SIZE bytes from SRAM into SPI NOR flash:
// WREN, PAGE PROGRAM per page, then RDSR polling until WIP clears.
module flash_prog_fsm #(
  parameter int unsigned PROG_SIZE       = 32,
  parameter logic [31:0] SRAM_BASE_ADDR  = 32'h0000_0000,
  parameter logic [23:0] FLASH_BASE_ADDR = 24'h00_0000,
  parameter logic [15:0] POLL_LIMIT      = 16'hFFFF
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  flash_prog_if.master bus
);

  typedef enum logic [4:0] {
    IDLE, WREN_SEND, WREN_WAIT, GAP_A,
    PP_SEND, PP_WAIT, ADDR_SEND, ADDR_WAIT,
    SRAM_RD, SRAM_LAT, DATA_SEND, DATA_WAIT,
    GAP_B, RDSR_SEND, RDSR_WAIT, ST_SEND,
    ST_WAIT, GAP_C, DONE, ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_faddr;
  logic [31:0] r_saddr;
  logic [31:0] r_bytes;
  logic [31:0] r_word;
  logic [15:0] r_polls;
  logic [1:0]  r_idx;

  logic [23:0] w_faddr_n;
  logic [31:0] w_bytes_n;
  logic [15:0] w_polls_n;
  logic [7:0]  w_abyte;
  logic [7:0]  w_dbyte;
  logic        w_accept;
  logic        w_wip;
  logic [6:0]  w_unused_status;

  assign w_faddr_n       = r_faddr + 24'd1;
  assign w_bytes_n       = r_bytes + 32'd1;
  assign w_polls_n       = r_polls + 16'd1;
  assign w_wip           = bus.spi_in_i[0];
  assign w_unused_status = bus.spi_in_i[7:1];
  assign bus.sram_addr_o = r_saddr;
  assign w_accept = start_i &&
    (r_state == IDLE || r_state == DONE || r_state == ERROR);

  always_comb begin
    w_abyte = r_faddr[7:0];
    unique case (r_idx)
      2'd0:    w_abyte = r_faddr[23:16];
      2'd1:    w_abyte = r_faddr[15:8];
      default: w_abyte = r_faddr[7:0];
    endcase
  end

  // Little-endian byte order, matching how the boot loader reassembles words
  always_comb begin
    w_dbyte = r_word[7:0];
    unique case (r_idx)
      2'd0: w_dbyte = r_word[7:0];
      2'd1: w_dbyte = r_word[15:8];
      2'd2: w_dbyte = r_word[23:16];
      2'd3: w_dbyte = r_word[31:24];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    bus.spi_start_o  = 1'b0;
    bus.spi_out_o    = 8'h00;
    bus.flash_csb_o  = 1'b0;
    bus.sram_rd_en_o = 1'b0;
    busy_o           = 1'b1;
    done_o           = 1'b0;
    error_o          = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.flash_csb_o = 1'b1;
        busy_o          = 1'b0;
        if (start_i) w_next = WREN_SEND;
      end
      WREN_SEND: begin
        bus.spi_out_o = 8'h06;
        if (!bus.spi_busy_i) begin
          bus.spi_start_o = 1'b1;
          w_next          = WREN_WAIT;
        end
      end
      WREN_WAIT: begin
        bus.spi_out_o = 8'h06;
        if (bus.spi_done_i) w_next = GAP_A;
      end
      GAP_A: begin
        bus.flash_csb_o = 1'b1;
        w_next          = PP_SEND;
      end
      PP_SEND: begin
        bus.spi_out_o = 8'h02;
        if (!bus.spi_busy_i) begin
          bus.spi_start_o = 1'b1;
          w_next          = PP_WAIT;
        end
      end
      PP_WAIT: begin
        bus.spi_out_o = 8'h02;
        if (bus.spi_done_i) w_next = ADDR_SEND;
      end
      ADDR_SEND: begin
        bus.spi_out_o = w_abyte;
        if (!bus.spi_busy_i) begin
          bus.spi_start_o = 1'b1;
          w_next          = ADDR_WAIT;
        end
      end
      ADDR_WAIT: begin
        bus.spi_out_o = w_abyte;
        if (bus.spi_done_i)
          w_next = (r_idx == 2'd2) ? SRAM_RD : ADDR_SEND;
      end
      SRAM_RD: begin
        bus.sram_rd_en_o = 1'b1;
        w_next           = SRAM_LAT;
      end
      SRAM_LAT: w_next = DATA_SEND;
      DATA_SEND: begin
        bus.spi_out_o = w_dbyte;
        if (!bus.spi_busy_i) begin
          bus.spi_start_o = 1'b1;
          w_next          = DATA_WAIT;
        end
      end
      DATA_WAIT: begin
        bus.spi_out_o = w_dbyte;
        if (bus.spi_done_i) begin
          if (r_idx != 2'd3)
            w_next = DATA_SEND;
          else if (w_bytes_n == PROG_SIZE || w_faddr_n[7:0] == 8'h00)
            w_next = GAP_B;
          else
            w_next = SRAM_RD;
        end
      end
      GAP_B: begin
        bus.flash_csb_o = 1'b1;
        w_next          = RDSR_SEND;
      end
      RDSR_SEND: begin
        bus.spi_out_o = 8'h05;
        if (!bus.spi_busy_i) begin
          bus.spi_start_o = 1'b1;
          w_next          = RDSR_WAIT;
        end
      end
      RDSR_WAIT: begin
        bus.spi_out_o = 8'h05;
        if (bus.spi_done_i) w_next = ST_SEND;
      end
      ST_SEND: begin
        if (!bus.spi_busy_i) begin
          bus.spi_start_o = 1'b1;
          w_next          = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.spi_done_i) begin
          if (!w_wip)                       w_next = GAP_C;
          else if (w_polls_n >= POLL_LIMIT) w_next = ERROR;
          else                              w_next = ST_SEND;
        end
      end
      GAP_C: begin
        bus.flash_csb_o = 1'b1;
        w_next = (r_bytes == PROG_SIZE) ? DONE : WREN_SEND;
      end
      DONE: begin
        bus.flash_csb_o = 1'b1;
        busy_o          = 1'b0;
        done_o          = 1'b1;
        if (start_i) w_next = WREN_SEND;
      end
      ERROR: begin
        bus.flash_csb_o = 1'b1;
        busy_o          = 1'b0;
        error_o         = 1'b1;
        if (start_i) w_next = WREN_SEND;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || w_accept) begin
      r_faddr <= FLASH_BASE_ADDR;
      r_saddr <= SRAM_BASE_ADDR;
      r_bytes <= 32'd0;
      r_word  <= 32'd0;
      r_polls <= 16'd0;
      r_idx   <= 2'd0;
    end else begin
      unique case (r_state)
        PP_WAIT:
          if (bus.spi_done_i) r_idx <= 2'd0;
        ADDR_WAIT:
          if (bus.spi_done_i) r_idx <= r_idx + 2'd1;
        SRAM_LAT: begin
          r_word <= bus.sram_data_i;
          r_idx  <= 2'd0;
        end
        DATA_WAIT: begin
          if (bus.spi_done_i) begin
            r_faddr <= w_faddr_n;
            r_bytes <= w_bytes_n;
            r_idx   <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_saddr <= r_saddr + 32'd4;
          end
        end
        GAP_B: r_polls <= 16'd0;
        ST_WAIT:
          if (bus.spi_done_i) r_polls <= w_polls_n;
        default: ;
      endcase
    end
  end

endmodule
